// File: rtl/data_selector_arb_if.sv
// Requester, source and consumer signal bundle for data_selector_arb.
interface data_selector_arb_if #(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned MAIN_INPUTS   = 16,
  parameter int unsigned REGS_INPUTS   = 64,
  parameter int unsigned NUM_BUSES     = 4,
  parameter int unsigned LANES_PER_BUS = 4
);
  localparam int unsigned SEL_W = $clog2(MAIN_INPUTS + REGS_INPUTS + 1);
  localparam int unsigned ID_W  = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;

  logic                                      busy;
  logic                                      regs_load;
  logic [REGS_INPUTS*DATA_WIDTH-1:0]         regs_in;
  logic [MAIN_INPUTS*DATA_WIDTH-1:0]         main_in;
  logic [NUM_BUSES-1:0]                      bus_req;
  logic [NUM_BUSES*LANES_PER_BUS*SEL_W-1:0]  bus_sel;
  logic [NUM_BUSES-1:0]                      bus_ack;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [DATA_WIDTH*LANES_PER_BUS-1:0]       data_out;
  logic [ID_W-1:0]                           out_bus_id;

  // Environment side: sources, requesters and consumer.
  modport master (
    output busy, regs_load, regs_in, main_in, bus_req, bus_sel, out_ready,
    input  bus_ack, out_valid, data_out, out_bus_id
  );

  // Selector side.
  modport slave (
    input  busy, regs_load, regs_in, main_in, bus_req, bus_sel, out_ready,
    output bus_ack, out_valid, data_out, out_bus_id
  );
endinterface

// File: rtl/data_selector_arb.sv
// Parametrised multi-bus lane selector: arbitrates one bus per cycle and
// registers its decoded lane words behind a valid/ready output stage.
module data_selector_arb #(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned MAIN_INPUTS   = 16,
  parameter int unsigned REGS_INPUTS   = 64,
  parameter int unsigned NUM_BUSES     = 4,
  parameter int unsigned LANES_PER_BUS = 4,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  data_selector_arb_if.slave  bus
);
  localparam int unsigned SEL_W     = $clog2(MAIN_INPUTS + REGS_INPUTS + 1);
  localparam int unsigned ID_W      = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;
  localparam int unsigned NUM_CODES = 1 << SEL_W;
  localparam int unsigned OUT_W     = DATA_WIDTH * LANES_PER_BUS;
  localparam int unsigned SNAP_W    = REGS_INPUTS * DATA_WIDTH;

  logic [SNAP_W-1:0]                   snap_q;
  logic [ID_W-1:0]                     ptr_q, ptr_d;
  logic                                valid_q, valid_d;
  logic [OUT_W-1:0]                    data_q, data_d;
  logic [ID_W-1:0]                     id_q, id_d;

  logic [DATA_WIDTH-1:0]               src_w [NUM_CODES];
  logic [NUM_BUSES-1:0][OUT_W-1:0]     bus_lanes_w;

  logic                                can_issue_c;
  logic                                issue_c;
  logic                                found_c;
  logic [NUM_BUSES-1:0]                rr_req_c;
  logic [NUM_BUSES-1:0]                cand_c;
  logic [NUM_BUSES-1:0]                grant_oh_c;
  logic [ID_W-1:0]                     grant_id_c;
  logic [OUT_W-1:0]                    grant_data_c;

  // Flat code table: main words, then snapshot words, zero for the rest.
  for (genvar k = 0; k < NUM_CODES; k++) begin : g_src
    if (k < MAIN_INPUTS) begin : g_main
      assign src_w[k] = bus.main_in[k*DATA_WIDTH +: DATA_WIDTH];
    end else if (k < MAIN_INPUTS + REGS_INPUTS) begin : g_regs
      assign src_w[k] = snap_q[(k-MAIN_INPUTS)*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_zero
      assign src_w[k] = '0;
    end
  end

  // Decode every lane of every bus; the arbiter picks one row.
  for (genvar b = 0; b < NUM_BUSES; b++) begin : g_bus
    for (genvar l = 0; l < LANES_PER_BUS; l++) begin : g_lane
      assign bus_lanes_w[b][l*DATA_WIDTH +: DATA_WIDTH] =
        src_w[bus.bus_sel[(b*LANES_PER_BUS+l)*SEL_W +: SEL_W]];
    end
  end

  assign can_issue_c = !bus.busy && (!valid_q || bus.out_ready);

  // Arbiter: lowest requester at/above the pointer, else lowest overall.
  // With fixed priority the pointer stays 0, so this reduces to lowest index.
  always_comb begin
    rr_req_c     = '0;
    cand_c       = '0;
    found_c      = 1'b0;
    grant_oh_c   = '0;
    grant_id_c   = '0;
    grant_data_c = '0;
    for (int unsigned b = 0; b < NUM_BUSES; b++) begin
      rr_req_c[b] = bus.bus_req[b] && (ID_W'(b) >= ptr_q);
    end
    cand_c = (|rr_req_c) ? rr_req_c : bus.bus_req;
    for (int unsigned b = 0; b < NUM_BUSES; b++) begin
      if (!found_c && cand_c[b]) begin
        found_c       = 1'b1;
        grant_oh_c[b] = 1'b1;
        grant_id_c    = ID_W'(b);
        grant_data_c  = bus_lanes_w[b];
      end
    end
  end

  assign issue_c     = rst && can_issue_c && found_c;
  assign bus.bus_ack = issue_c ? grant_oh_c : '0;

  // Next state for the output stage and round-robin pointer.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    if (issue_c) begin
      valid_d = 1'b1;
      data_d  = grant_data_c;
      id_d    = grant_id_c;
      if (PRIORITY_MODE == 0) begin
        ptr_d = (grant_id_c == ID_W'(NUM_BUSES - 1)) ? '0 : grant_id_c + ID_W'(1);
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Register-file snapshot; a same-cycle grant still sees the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q <= '0;
    end else if (bus.regs_load) begin
      snap_q <= bus.regs_in;
    end
  end

  // Output stage and arbitration pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.data_out   = data_q;
  assign bus.out_bus_id = id_q;

endmodule

// File: tb/tb_data_selector_arb.sv
// Directed bench for data_selector_arb: a round-robin instance plus a
// fixed-priority instance driven from the same stimulus.
module tb_data_selector_arb;
  localparam int unsigned DW = 4;
  localparam int unsigned MI = 16;
  localparam int unsigned RI = 64;
  localparam int unsigned NB = 4;
  localparam int unsigned LP = 4;
  localparam int unsigned SW = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 busy;
  logic                 regs_load;
  logic                 out_ready;
  logic [RI*DW-1:0]     regs_in;
  logic [MI*DW-1:0]     main_in;
  logic [NB-1:0]        bus_req;
  logic [NB*LP*SW-1:0]  bus_sel;

  data_selector_arb_if #(.DATA_WIDTH(DW), .MAIN_INPUTS(MI), .REGS_INPUTS(RI),
                         .NUM_BUSES(NB), .LANES_PER_BUS(LP)) rr_if ();
  data_selector_arb_if #(.DATA_WIDTH(DW), .MAIN_INPUTS(MI), .REGS_INPUTS(RI),
                         .NUM_BUSES(NB), .LANES_PER_BUS(LP)) fp_if ();

  assign rr_if.busy      = busy;
  assign rr_if.regs_load = regs_load;
  assign rr_if.regs_in   = regs_in;
  assign rr_if.main_in   = main_in;
  assign rr_if.bus_req   = bus_req;
  assign rr_if.bus_sel   = bus_sel;
  assign rr_if.out_ready = out_ready;
  assign fp_if.busy      = busy;
  assign fp_if.regs_load = regs_load;
  assign fp_if.regs_in   = regs_in;
  assign fp_if.main_in   = main_in;
  assign fp_if.bus_req   = bus_req;
  assign fp_if.bus_sel   = bus_sel;
  assign fp_if.out_ready = out_ready;

  data_selector_arb #(.DATA_WIDTH(DW), .MAIN_INPUTS(MI), .REGS_INPUTS(RI),
                      .NUM_BUSES(NB), .LANES_PER_BUS(LP), .PRIORITY_MODE(0))
    u_rr (.clk(clk), .rst(rst_n), .bus(rr_if.slave));

  data_selector_arb #(.DATA_WIDTH(DW), .MAIN_INPUTS(MI), .REGS_INPUTS(RI),
                      .NUM_BUSES(NB), .LANES_PER_BUS(LP), .PRIORITY_MODE(1))
    u_fp (.clk(clk), .rst(rst_n), .bus(fp_if.slave));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_sel(input int b, input logic [SW-1:0] l3, input logic [SW-1:0] l2,
                         input logic [SW-1:0] l1, input logic [SW-1:0] l0);
    bus_sel[(b*LP+0)*SW +: SW] = l0;
    bus_sel[(b*LP+1)*SW +: SW] = l1;
    bus_sel[(b*LP+2)*SW +: SW] = l2;
    bus_sel[(b*LP+3)*SW +: SW] = l3;
  endtask

  task automatic set_main(input int k, input logic [DW-1:0] v);
    main_in[k*DW +: DW] = v;
  endtask

  task automatic set_regs(input int k, input logic [DW-1:0] v);
    regs_in[k*DW +: DW] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_oh;
    int         exp_g;
    rst_n     = 1'b0;
    busy      = 1'b0;
    regs_load = 1'b0;
    out_ready = 1'b1;
    regs_in   = '0;
    main_in   = '0;
    bus_req   = '0;
    bus_sel   = '0;

    // Reset and idle
    tick(); tick();
    #1;
    check("rst_valid", 32'(rr_if.out_valid), 32'd0);
    check("rst_data",  32'(rr_if.data_out),  32'd0);
    check("rst_id",    32'(rr_if.out_bus_id), 32'd0);
    check("rst_ack",   32'(rr_if.bus_ack),   32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      check("idle_valid", 32'(rr_if.out_valid), 32'd0);
      check("idle_data",  32'(rr_if.data_out),  32'd0);
      check("idle_ack",   32'(rr_if.bus_ack),   32'd0);
    end
    check("idle_id", 32'(rr_if.out_bus_id), 32'd0);

    // Single grant: lanes {127,21,3,3} -> {0, snap[5]=7, main[3]=A, main[3]=A}
    tick();
    set_main(3, 4'hA);
    set_regs(5, 4'h7);
    regs_load = 1'b1;
    tick();
    regs_load = 1'b0;
    set_sel(2, 7'd127, 7'd21, 7'd3, 7'd3);
    bus_req = 4'b0100;
    #1 check("single_ack", 32'(rr_if.bus_ack), 32'h4);
    tick();
    bus_req = 4'b0000;
    #1;
    check("single_data",  32'(rr_if.data_out),   32'h07AA);
    check("single_id",    32'(rr_if.out_bus_id), 32'd2);
    check("single_valid", 32'(rr_if.out_valid),  32'd1);
    check("single_ack0",  32'(rr_if.bus_ack),    32'd0);
    tick(); #1;
    check("drain_valid", 32'(rr_if.out_valid), 32'd0);
    check("drain_hold",  32'(rr_if.data_out),  32'h07AA);

    // Fresh reset so the pointer starts at bus 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Round robin with all buses requesting; bus b reads main word b = b+1
    for (int b = 0; b < 4; b++) begin
      set_main(b, 4'(b + 1));
      set_sel(b, 7'd127, 7'd127, 7'd127, 7'(b));
    end
    bus_req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      exp_g  = i % 4;
      exp_oh = 4'b0001 << exp_g;
      #1;
      check("rr_ack", 32'(rr_if.bus_ack), 32'(exp_oh));
      check("fp_ack", 32'(fp_if.bus_ack), 32'h1);
      if (i > 0) begin
        check("rr_id",    32'(rr_if.out_bus_id), 32'((i - 1) % 4));
        check("rr_data",  32'(rr_if.data_out),   32'((i - 1) % 4 + 1));
        check("rr_valid", 32'(rr_if.out_valid),  32'd1);
        check("fp_id",    32'(fp_if.out_bus_id), 32'd0);
      end
      tick();
    end

    // Backpressure: last grant (bus 1, data 2) frozen while out_ready=0
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ack",   32'(rr_if.bus_ack),    32'd0);
      check("bp_data",  32'(rr_if.data_out),   32'h0002);
      check("bp_id",    32'(rr_if.out_bus_id), 32'd1);
      check("bp_valid", 32'(rr_if.out_valid),  32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1 check("bp_release_ack", 32'(rr_if.bus_ack), 32'h4);
    tick();
    bus_req = 4'b0000;
    #1;
    check("bp_release_id",   32'(rr_if.out_bus_id), 32'd2);
    check("bp_release_data", 32'(rr_if.data_out),   32'h0003);

    // busy: no grants for 3 cycles, pending output drains, pointer stays at 3
    busy = 1'b1;
    bus_req = 4'b1001;
    set_sel(0, 7'd127, 7'd127, 7'd127, 7'd16);
    set_sel(3, 7'd127, 7'd127, 7'd127, 7'd16);
    set_regs(0, 4'h1);
    regs_load = 1'b1;
    #1 check("busy_ack0", 32'(rr_if.bus_ack), 32'd0);
    tick();
    regs_load = 1'b0;
    #1;
    check("busy_ack1",  32'(rr_if.bus_ack),   32'd0);
    check("busy_drain", 32'(rr_if.out_valid), 32'd0);
    tick();
    #1 check("busy_ack2", 32'(rr_if.bus_ack), 32'd0);
    tick();

    // Snapshot race: load 0x9 coincides with a grant reading code 16
    busy = 1'b0;
    set_regs(0, 4'h9);
    regs_load = 1'b1;
    #1 check("race_ack", 32'(rr_if.bus_ack), 32'h8);
    tick();
    regs_load = 1'b0;
    bus_req = 4'b0001;
    #1;
    check("race_old_data", 32'(rr_if.data_out),   32'h0001);
    check("race_old_id",   32'(rr_if.out_bus_id), 32'd3);
    check("race_ack2",     32'(rr_if.bus_ack),    32'h1);
    tick();
    bus_req = 4'b0000;
    #1;
    check("race_new_data", 32'(rr_if.data_out),   32'h0009);
    check("race_new_id",   32'(rr_if.out_bus_id), 32'd0);
    check("race_valid",    32'(rr_if.out_valid),  32'd1);

    // Async reset mid-stream while holding a valid output
    out_ready = 1'b0;
    bus_req = 4'b1111;
    #1 check("hold_ack", 32'(rr_if.bus_ack), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(rr_if.out_valid),  32'd0);
    check("arst_data",  32'(rr_if.data_out),   32'd0);
    check("arst_id",    32'(rr_if.out_bus_id), 32'd0);
    check("arst_ack",   32'(rr_if.bus_ack),    32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("post_rst_ack", 32'(rr_if.bus_ack), 32'h1);
    tick();
    bus_req = 4'b0000;
    #1;
    check("post_rst_id",    32'(rr_if.out_bus_id), 32'd0);
    check("post_rst_valid", 32'(rr_if.out_valid),  32'd1);
    check("post_rst_data",  32'(rr_if.data_out),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
